flux_scheduler: RTL and testbench
=================================

# flux_scheduler

Round-robin flux scheduler placed between the per-flux input FIFOs and a shared multi-flux parametric actor. It grants exactly one flux at a time and exposes only that flux's empty flags to the actor. The grant is held for an atomic burst of NUM_OP tokens, so the actor's accumulation window always finishes on the same tag. The actor therefore never sees a tag change mid-operation and never needs a forced close.

## Interface
- PORTS, 2, input ports per flux.
- FLUX, 2, number of fluxes (>=2).
- NUM_OP, 4, tokens per burst (>=1).
- TAG_WIDTH, $clog2(FLUX), tag width.

- ck  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  when 0, no new grant is issued; an ongoing ARM or BURST continues.
- req_empty  input  PORTS*FLUX  upstream FIFO empty flags; bit i+j*PORTS = port i of flux j.
- act_read  input  PORTS*FLUX  read strobes from the actor; same bit ordering.
- act_empty  output  PORTS*FLUX  empty flags presented to the actor.
- fifo_read  output  PORTS*FLUX  read strobes forwarded to the upstream FIFOs.
- grant  output  FLUX  one-hot grant, registered.
- grant_tag  output  TAG_WIDTH  index of the granted flux, registered.
- busy  output  1  high while in BURST.
- burst_done  output  1  one-cycle pulse after a burst completes.
- protocol_err  output  1  sticky error flag.

## Operation
- Flux j is "available" when all PORTS bits of j in req_empty are 0.
- A token of the granted flux g is "consumed" in a cycle when all PORTS act_read bits of g are 1 and flux g is available.
- Masking (combinational from registered grant):
  - act_empty: bits of g equal req_empty; all other bits are 1.
  - fifo_read: bits of g equal act_read; all other bits are 0.
  - In IDLE, act_empty is all 1 and fifo_read is all 0.
- States:
  - IDLE: grant=0. If enable=1 and any flux is available, pick the first available flux scanning upward from (last_tag+1) mod FLUX, with wrap. Next state is ARM, with grant/grant_tag loaded and cnt=0.
  - ARM: grant held, nothing consumed yet.
    - Token consumed: if NUM_OP==1, the burst completes; otherwise cnt=1 and next state is BURST.
    - Granted flux not available and no token consumed: release the grant, go to IDLE, last_tag unchanged.
  - BURST: the grant is held unconditionally, whatever the emptiness of g, the state of enable, or requests from other fluxes.
    - Each consumed token increments cnt.
    - When the token with cnt==NUM_OP-1 is consumed, the burst completes.
- Burst completion: next state IDLE, last_tag<=g, cnt<=0, grant<=0, burst_done<=1 for one cycle.
- cnt has width $clog2(NUM_OP+1) and never exceeds NUM_OP-1.
- protocol_err sets and stays set until rst when either:
  - any act_read bit of a non-granted flux is 1 (or any bit at all in IDLE);
  - only some, not all, of the PORTS act_read bits of g are 1. Such a partial read is not counted as a token; its bits are still forwarded via fifo_read.
- Reset (including mid-burst): state IDLE, cnt 0, last_tag FLUX-1 (flux 0 has first priority), protocol_err cleared.

## Timing
- Reset values: grant 0, grant_tag 0, busy 0, burst_done 0, protocol_err 0, act_empty all 1, fifo_read all 0.
- Request to grant: flux available in an IDLE cycle means grant asserted in the next cycle.
- Back-to-back bursts: after the completing edge there is exactly one IDLE cycle, which coincides with the burst_done pulse. The next grant appears the cycle after that.
- busy follows state==BURST (registered). It is 0 in ARM and IDLE.
- act_empty and fifo_read respond combinationally within the same cycle to req_empty and act_read. The grant can only change on a clock edge.
- Simultaneous events:
  - Burst completion and a new request in the same cycle: the completion takes effect; arbitration happens in the following IDLE cycle using the updated last_tag.
  - rst has priority over all other events.

## Test plan
- Reset check: assert rst for 2 cycles with all fluxes available -> all outputs at their reset values; one cycle after release, grant=01 and grant_tag=0.
- Continuous traffic (FLUX=2, PORTS=2, NUM_OP=4), both fluxes available, actor reads every cycle -> 4 tokens on flux 0, burst_done pulse, one idle cycle, then 4 tokens on flux 1; the pattern repeats with a 0,1,0,1 grant sequence.
- Mid-burst starvation: flux 0 goes empty after 2 tokens while flux 1 stays available -> grant remains 01, flux-1 bits of act_empty stay 1; when flux 0 refills, 2 more tokens complete the burst, then flux 1 is granted.
- ARM release: flux 0 is granted, then its port 1 goes empty before any read -> next cycle IDLE, grant 0; the cycle after, grant=10; protocol_err stays 0.
- Protocol error: while flux 0 is granted, drive act_read bit 2 (flux 1, port 0) -> fifo_read bit 2 stays 0 and protocol_err=1 from the next cycle until rst.
- Reset mid-burst: rst after 3 tokens on flux 1 -> IDLE; on release flux 0 is granted first, and a full 4 tokens are required before burst_done.

Source files
------------

// File: rtl/flux_scheduler.sv
// Round-robin flux scheduler: grants one flux at a time for an atomic burst of
// NUM_OP tokens and masks the FIFO empty/read handshakes to the granted flux.
module flux_scheduler #(
    parameter int PORTS     = 2,
    parameter int FLUX      = 2,
    parameter int NUM_OP    = 4,
    parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [PORTS*FLUX-1:0]  req_empty,
    input  logic [PORTS*FLUX-1:0]  act_read,
    output logic [PORTS*FLUX-1:0]  act_empty,
    output logic [PORTS*FLUX-1:0]  fifo_read,
    output logic [FLUX-1:0]        grant,
    output logic [TAG_WIDTH-1:0]   grant_tag,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   protocol_err
);

    localparam int CNT_W = $clog2(NUM_OP + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_OP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FLUX-1:0]      grant_q, grant_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [TAG_WIDTH-1:0] last_tag_q, last_tag_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [FLUX-1:0]      avail, rd_all, rd_any;
    logic                 g_avail, g_rd_all, consumed, err_now;
    logic                 pick_found;
    logic [TAG_WIDTH-1:0] pick_idx;
    logic [FLUX-1:0]      pick_onehot;

    always_comb begin
        for (int j = 0; j < FLUX; j++) begin
            avail[j]  = ~|req_empty[j*PORTS +: PORTS];
            rd_all[j] = &act_read[j*PORTS +: PORTS];
            rd_any[j] = |act_read[j*PORTS +: PORTS];
        end
    end

    // Only the granted flux sees its real handshakes; everyone else looks empty/idle.
    always_comb begin
        act_empty = '1;
        fifo_read = '0;
        for (int j = 0; j < FLUX; j++) begin
            if (grant_q[j]) begin
                act_empty[j*PORTS +: PORTS] = req_empty[j*PORTS +: PORTS];
                fifo_read[j*PORTS +: PORTS] = act_read[j*PORTS +: PORTS];
            end
        end
    end

    assign g_avail  = |(grant_q & avail);
    assign g_rd_all = |(grant_q & rd_all);
    assign consumed = g_rd_all & g_avail;
    assign err_now  = |(~grant_q & rd_any) | |(grant_q & rd_any & ~rd_all);

    // Round-robin scan starting just after the last completed flux.
    always_comb begin : arb
        logic [TAG_WIDTH-1:0] idx;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        idx         = '0;
        for (int k = 1; k <= FLUX; k++) begin
            idx = TAG_WIDTH'((int'(last_tag_q) + k) % FLUX);
            if (!pick_found && avail[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin : next_state
        logic complete;
        state_d    = state_q;
        grant_d    = grant_q;
        tag_d      = tag_q;
        last_tag_d = last_tag_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = err_q | err_now;
        complete   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && pick_found) begin
                    state_d = S_ARM;
                    grant_d = pick_onehot;
                    tag_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            S_ARM: begin
                if (consumed) begin
                    if (NUM_OP == 1) begin
                        complete = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_BURST;
                    end
                end else if (!g_avail) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_BURST: begin
                // Grant is locked here regardless of emptiness, enable or other requests.
                if (consumed) begin
                    if (cnt_q == CNT_LAST) begin
                        complete = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (complete) begin
            state_d    = S_IDLE;
            last_tag_d = tag_q;
            cnt_d      = '0;
            grant_d    = '0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            tag_q      <= '0;
            last_tag_q <= TAG_WIDTH'(FLUX - 1);
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            tag_q      <= tag_d;
            last_tag_q <= last_tag_d;
            cnt_q      <= cnt_d;
            busy_q     <= (state_d == S_BURST);
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign grant        = grant_q;
    assign grant_tag    = tag_q;
    assign busy         = busy_q;
    assign burst_done   = done_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_flux_scheduler.sv
// Directed bench for flux_scheduler with FLUX=2, PORTS=2, NUM_OP=4.
module tb_flux_scheduler;

    logic       ck = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] req_empty;
    logic [3:0] act_read;
    logic [3:0] act_empty;
    logic [3:0] fifo_read;
    logic [1:0] grant;
    logic [0:0] grant_tag;
    logic       busy;
    logic       burst_done;
    logic       protocol_err;

    int n_checks = 0;
    int n_errors = 0;

    flux_scheduler #(.PORTS(2), .FLUX(2), .NUM_OP(4)) dut (
        .ck          (ck),
        .rst         (rst),
        .enable      (enable),
        .req_empty   (req_empty),
        .act_read    (act_read),
        .act_empty   (act_empty),
        .fifo_read   (fifo_read),
        .grant       (grant),
        .grant_tag   (grant_tag),
        .busy        (busy),
        .burst_done  (burst_done),
        .protocol_err(protocol_err)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; req_empty = 4'b0000; act_read = 4'b0000;
        tick(); tick();
        check("rst_grant", grant, 2'b00);
        check("rst_tag", grant_tag, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", burst_done, 1'b0);
        check("rst_err", protocol_err, 1'b0);
        check("rst_act_empty", act_empty, 4'hF);
        check("rst_fifo_read", fifo_read, 4'h0);

        rst = 1'b0;
        tick();
        check("first_grant", grant, 2'b01);
        check("first_tag", grant_tag, 1'b0);
        check("arm_act_empty", act_empty, 4'b1100);
        check("arm_busy", busy, 1'b0);

        // Continuous traffic: flux 0 burst
        act_read = 4'b0011;
        #1 check("fwd_read_f0", fifo_read, 4'b0011);
        tick(); check("b0_busy1", busy, 1'b1);
        tick(); tick();
        check("b0_not_done", burst_done, 1'b0);
        check("b0_grant_hold", grant, 2'b01);
        tick();
        act_read = 4'b0000;
        check("b0_done", burst_done, 1'b1);
        check("b0_idle_grant", grant, 2'b00);
        check("b0_idle_busy", busy, 1'b0);
        check("b0_idle_act_empty", act_empty, 4'hF);
        tick();
        check("rr_grant_f1", grant, 2'b10);
        check("rr_tag_f1", grant_tag, 1'b1);
        check("done_one_cycle", burst_done, 1'b0);

        // flux 1 burst
        act_read = 4'b1100;
        for (int i = 0; i < 4; i++) tick();
        act_read = 4'b0000;
        check("b1_done", burst_done, 1'b1);
        check("b1_idle_grant", grant, 2'b00);
        tick();
        check("rr_grant_f0_again", grant, 2'b01);

        // Mid-burst starvation of flux 0 after 2 tokens
        act_read = 4'b0011;
        tick(); tick();
        req_empty = 4'b0001; act_read = 4'b0000;
        tick(); tick(); tick();
        check("starve_grant", grant, 2'b01);
        check("starve_busy", busy, 1'b1);
        check("starve_act_empty", act_empty, 4'b1101);
        req_empty = 4'b0000; act_read = 4'b0011;
        tick();
        check("starve_tok3_not_done", burst_done, 1'b0);
        tick();
        act_read = 4'b0000;
        check("starve_done", burst_done, 1'b1);
        tick();
        check("starve_next_f1", grant, 2'b10);

        // finish flux 1 burst so flux 0 is granted next
        act_read = 4'b1100;
        for (int i = 0; i < 4; i++) tick();
        act_read = 4'b0000;
        tick();
        check("pre_arm_grant_f0", grant, 2'b01);

        // ARM release: flux 0 port 1 empties before any read
        req_empty = 4'b0010;
        tick();
        check("arm_release_grant", grant, 2'b00);
        check("arm_release_done", burst_done, 1'b0);
        tick();
        check("arm_release_next", grant, 2'b10);
        check("arm_release_err", protocol_err, 1'b0);

        // flux 1 burst, then flux 0 granted
        req_empty = 4'b0000; act_read = 4'b1100;
        for (int i = 0; i < 4; i++) tick();
        act_read = 4'b0000;
        tick();
        check("pre_err_grant_f0", grant, 2'b01);

        // Protocol error: read of non-granted flux 1 port 0
        act_read = 4'b0100;
        #1 check("err_fifo_masked", fifo_read, 4'b0000);
        check("err_not_yet", protocol_err, 1'b0);
        tick();
        act_read = 4'b0000;
        check("err_set", protocol_err, 1'b1);
        tick();
        check("err_sticky", protocol_err, 1'b1);

        // flux 0 burst, then flux 1 gets 3 tokens before a reset
        act_read = 4'b0011;
        for (int i = 0; i < 4; i++) tick();
        act_read = 4'b0000;
        tick();
        check("pre_rst_grant_f1", grant, 2'b10);
        act_read = 4'b1100;
        tick(); tick(); tick();
        check("mid_busy", busy, 1'b1);
        rst = 1'b1; act_read = 4'b0000;
        tick();
        check("midrst_grant", grant, 2'b00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err_clr", protocol_err, 1'b0);
        rst = 1'b0;
        tick();
        check("postrst_grant_f0", grant, 2'b01);
        check("postrst_tag", grant_tag, 1'b0);
        act_read = 4'b0011;
        tick(); tick(); tick();
        check("postrst_3tok_not_done", burst_done, 1'b0);
        tick();
        act_read = 4'b0000;
        check("postrst_done", burst_done, 1'b1);

        // enable=0 blocks new grants
        enable = 1'b0;
        tick(); tick();
        check("disable_no_grant", grant, 2'b00);
        enable = 1'b1;
        tick();
        check("enable_grant_f1", grant, 2'b10);

        // Partial read of the granted flux: forwarded but flagged
        act_read = 4'b0100;
        #1 check("partial_fwd", fifo_read, 4'b0100);
        tick();
        act_read = 4'b0000;
        check("partial_err", protocol_err, 1'b1);
        check("partial_no_token", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
